// File: rtl/palette_pkg.sv
// Shared defaults, types and helpers for the palette lookup block.
package palette_pkg;

  localparam int DEF_IDX_W           = 4;
  localparam int DEF_COLOR_W         = 24;
  localparam int DEF_NUM_BANKS       = 4;
  localparam int DEF_TRANSPARENT_IDX = 0;

  // Bank select width; a single bank still gets a 1-bit select.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam logic [23:0] TRANSPARENT_COLOR = 24'h000000;

endpackage

// File: rtl/palette_fade.sv
// Combinational per-channel fade: ch_out = (ch * (fade + 1)) >> 8.
// fade = 255 is identity, fade = 0 blanks the colour.
module palette_fade
  import palette_pkg::*;
(
  input  logic [23:0] i_color,
  input  logic [7:0]  i_fade,
  output logic [23:0] o_color
);

  rgb888_t c_in;
  rgb888_t c_out;

  // 8x9-bit product always fits in 16 bits (255 * 256 = 65280).
  function automatic logic [7:0] scale(input logic [7:0] ch, input logic [7:0] f);
    logic [15:0] p;
    p = 16'(ch) * (16'(f) + 16'd1);
    return 8'(p >> 8);
  endfunction

  // Scale each channel independently.
  always_comb begin
    c_in    = rgb888_t'(i_color);
    c_out   = '0;
    c_out.r = scale(c_in.r, i_fade);
    c_out.g = scale(c_in.g, i_fade);
    c_out.b = scale(c_in.b, i_fade);
  end

  assign o_color = c_out;

endmodule

// File: rtl/palette_lut.sv
// Multi-bank runtime-loadable colour palette, 2-stage lookup pipeline.
// Optional fade scaler enabled by defining PALETTE_FADE_EN.
// Bank switches only take effect on i_frame_start so a frame never
// mixes palettes.
module palette_lut
  import palette_pkg::*;
#(
  parameter  int IDX_W           = DEF_IDX_W,
  parameter  int COLOR_W         = DEF_COLOR_W,
  parameter  int NUM_BANKS       = DEF_NUM_BANKS,
  parameter  int TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
  localparam int BANK_W          = bank_w(NUM_BANKS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [BANK_W-1:0]  i_wr_bank,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [COLOR_W-1:0] i_wr_color,
  input  logic [BANK_W-1:0]  i_bank_sel,
  input  logic               i_frame_start,
`ifdef PALETTE_FADE_EN
  input  logic [7:0]         i_fade,
`endif
  input  logic               i_pix_valid,
  input  logic [IDX_W-1:0]   i_pix_idx,
  output logic               o_pix_valid,
  output logic [COLOR_W-1:0] o_pix_color,
  output logic               o_pix_transparent,
  output logic [BANK_W-1:0]  o_active_bank
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int STAGES  = 2;

  logic [COLOR_W-1:0] mem [NUM_BANKS][ENTRIES];
  logic [STAGES:1]    vld_pipe;
  logic [IDX_W-1:0]   idx1;
  logic [BANK_W-1:0]  bank1;
  logic               sel_ok;
  logic               is_transp;
  logic               fwd;
  logic [COLOR_W-1:0] lut_color;
  logic [COLOR_W-1:0] shaded;

  // Requested bank is legal only if it names an existing bank.
  assign sel_ok = {1'b0, i_bank_sel} < (BANK_W+1)'(NUM_BANKS);

  // Palette storage: out-of-range banks and the transparent entry never
  // match a write, so the transparent entry stays 0 forever.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < ENTRIES; e++)
          mem[b][e] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < ENTRIES; e++)
          if (i_wr_en && i_wr_bank == BANK_W'(b) && i_wr_idx == IDX_W'(e) &&
              e != TRANSPARENT_IDX)
            mem[b][e] <= i_wr_color;
    end
  end

  // Active bank register, updated only on a frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_active_bank <= '0;
    else if (i_frame_start && sel_ok)
      o_active_bank <= i_bank_sel;
  end

  // Valid shift register through both stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      vld_pipe <= '0;
    else
      vld_pipe <= {vld_pipe[STAGES-1:1], i_pix_valid};
  end

  assign o_pix_valid = vld_pipe[STAGES];

`ifdef PALETTE_FADE_EN
  logic [7:0] fade1;
`endif

  // S1: capture pixel index with the bank in force this cycle (old bank
  // on a frame_start cycle).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx1  <= '0;
      bank1 <= '0;
`ifdef PALETTE_FADE_EN
      fade1 <= '0;
`endif
    end else begin
      idx1  <= i_pix_idx;
      bank1 <= o_active_bank;
`ifdef PALETTE_FADE_EN
      fade1 <= i_fade;
`endif
    end
  end

  // S2 read with write-first forwarding of a same-edge write.
  always_comb begin
    is_transp = (idx1 == IDX_W'(TRANSPARENT_IDX));
    fwd       = i_wr_en && (i_wr_bank == bank1) && (i_wr_idx == idx1);
    lut_color = fwd ? i_wr_color : mem[bank1][idx1];
  end

`ifdef PALETTE_FADE_EN
  if (COLOR_W != 24) begin : g_bad_width
    $error("palette_lut: PALETTE_FADE_EN requires COLOR_W == 24");
  end

  palette_fade u_fade (
    .i_color (lut_color),
    .i_fade  (fade1),
    .o_color (shaded)
  );
`else
  assign shaded = lut_color;
`endif

  // S2 output registers; colour holds across bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_transparent <= 1'b0;
      o_pix_color       <= '0;
    end else begin
      o_pix_transparent <= vld_pipe[1] & is_transp;
      if (vld_pipe[1])
        o_pix_color <= is_transp ? COLOR_W'(TRANSPARENT_COLOR) : shaded;
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut with a palette-level reference model.
// Built with 3 banks so the 2-bit bank ports can encode an illegal bank (3).
module tb_palette_lut;

  localparam int IDX_W   = 4;
  localparam int COLOR_W = 24;
  localparam int NB      = 3;
  localparam int BW      = 2;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_wr_en = 1'b0;
  logic [BW-1:0]      i_wr_bank = '0;
  logic [IDX_W-1:0]   i_wr_idx = '0;
  logic [COLOR_W-1:0] i_wr_color = '0;
  logic [BW-1:0]      i_bank_sel = '0;
  logic               i_frame_start = 1'b0;
  logic [7:0]         i_fade = 8'd255;
  logic               i_pix_valid = 1'b0;
  logic [IDX_W-1:0]   i_pix_idx = '0;
  logic               o_pix_valid;
  logic [COLOR_W-1:0] o_pix_color;
  logic               o_pix_transparent;
  logic [BW-1:0]      o_active_bank;

  palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .NUM_BANKS(NB), .TRANSPARENT_IDX(0)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_wr_en           (i_wr_en),
    .i_wr_bank         (i_wr_bank),
    .i_wr_idx          (i_wr_idx),
    .i_wr_color        (i_wr_color),
    .i_bank_sel        (i_bank_sel),
    .i_frame_start     (i_frame_start),
`ifdef PALETTE_FADE_EN
    .i_fade            (i_fade),
`endif
    .i_pix_valid       (i_pix_valid),
    .i_pix_idx         (i_pix_idx),
    .o_pix_valid       (o_pix_valid),
    .o_pix_color       (o_pix_color),
    .o_pix_transparent (o_pix_transparent),
    .o_active_bank     (o_active_bank)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  bit run_cmp  = 1'b0;

  // Reference model state
  logic [23:0] mem_m [NB][16];
  int          active_m;
  bit          pend_v;
  int          pend_idx, pend_bank, pend_fade;
  bit          exp_v, exp_t;
  logic [23:0] exp_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] shade(input logic [23:0] c, input int f);
`ifdef PALETTE_FADE_EN
    int r, g, b;
    r = int'(c[23:16]) * (f + 1) / 256;
    g = int'(c[15:8])  * (f + 1) / 256;
    b = int'(c[7:0])   * (f + 1) / 256;
    return {8'(r), 8'(g), 8'(b)};
`else
    return (f >= 0) ? c : c;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < 16; e++)
        mem_m[b][e] = '0;
    active_m = 0; pend_v = 0; pend_idx = 0; pend_bank = 0; pend_fade = 255;
    exp_v = 0; exp_t = 0; exp_c = '0;
  endtask

  // One clock: the model advances on the edge, inputs are changed after the
  // following falling edge. Writes landing on an edge are seen by the
  // pixel that completes on that edge.
  task automatic cyc();
    @(posedge i_clk);
    if (i_rst_n) begin
      if (i_wr_en && int'(i_wr_bank) < NB && i_wr_idx != 0)
        mem_m[i_wr_bank][i_wr_idx] = i_wr_color;
      exp_v = pend_v;
      if (pend_v) begin
        exp_t = (pend_idx == 0);
        exp_c = exp_t ? 24'h0 : shade(mem_m[pend_bank][pend_idx], pend_fade);
      end
      pend_v    = i_pix_valid;
      pend_idx  = int'(i_pix_idx);
      pend_bank = active_m;
      pend_fade = int'(i_fade);
      if (i_frame_start && int'(i_bank_sel) < NB)
        active_m = int'(i_bank_sel);
    end
    @(negedge i_clk);
  endtask

  task automatic wr(input int bank, input int idx, input logic [23:0] col);
    i_wr_en = 1; i_wr_bank = BW'(bank); i_wr_idx = IDX_W'(idx); i_wr_color = col;
    cyc();
    i_wr_en = 0;
  endtask

  task automatic fs(input int sel);
    i_frame_start = 1; i_bank_sel = BW'(sel);
    cyc();
    i_frame_start = 0;
  endtask

  // Single lookup from idle: nothing valid after edge N, result after N+1.
  task automatic lookup(input int idx, input logic [23:0] ec, input bit et, input string name);
    i_pix_valid = 1; i_pix_idx = IDX_W'(idx);
    cyc();
    chk({name, "_early"}, 32'(o_pix_valid), 32'd0);
    i_pix_valid = 0;
    cyc();
    chk({name, "_v"}, 32'(o_pix_valid), 32'd1);
    chk({name, "_c"}, 32'(o_pix_color), 32'(ec));
    chk({name, "_t"}, 32'(o_pix_transparent), 32'(et));
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge i_clk) begin
    if (run_cmp && i_rst_n) begin
      chk("cmp_valid", 32'(o_pix_valid), 32'(exp_v));
      if (exp_v) begin
        chk("cmp_color", 32'(o_pix_color), 32'(exp_c));
        chk("cmp_transp", 32'(o_pix_transparent), 32'(exp_t));
      end
      chk("cmp_bank", 32'(o_active_bank), 32'(active_m));
      if (o_pix_valid) n_valid++;
    end
  end

  initial begin
    model_reset();
    i_rst_n = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_bank",   32'(o_active_bank), 32'd0);
    chk("rst_valid",  32'(o_pix_valid), 32'd0);
    chk("rst_color",  32'(o_pix_color), 32'd0);
    chk("rst_transp", 32'(o_pix_transparent), 32'd0);
    i_rst_n = 1;
    run_cmp = 1;
    cyc();

    // Sweep bank 0 after reset: all zero, only idx 0 transparent
    for (int i = 0; i < 16; i++) begin
      i_pix_valid = 1; i_pix_idx = IDX_W'(i);
      cyc();
    end
    i_pix_valid = 0;
    cyc(); cyc();
    lookup(0, 24'h0, 1'b1, "rst_idx0");
    lookup(9, 24'h0, 1'b0, "rst_idx9");

    // Load bank 1 and switch to it
    wr(1, 3, 24'hb6b3b1);
    fs(1);
    chk("sw_bank", 32'(o_active_bank), 32'd1);
    lookup(3, 24'hb6b3b1, 1'b0, "b1_idx3");

    // Pixel in the frame_start cycle uses the old bank
    fs(0);
    wr(0, 5, 24'h444446);
    wr(1, 5, 24'h7f7f80);
    i_frame_start = 1; i_bank_sel = 2'd1; i_pix_valid = 1; i_pix_idx = 4'd5;
    cyc();
    i_frame_start = 0;
    cyc();
    chk("fs_old_v", 32'(o_pix_valid), 32'd1);
    chk("fs_old_c", 32'(o_pix_color), 32'h444446);
    i_pix_valid = 0;
    cyc();
    chk("fs_new_v", 32'(o_pix_valid), 32'd1);
    chk("fs_new_c", 32'(o_pix_color), 32'h7f7f80);
    cyc();

    // Write landing on the S2 edge of a lookup is forwarded
    wr(1, 7, 24'h111111);
    lookup(7, 24'h111111, 1'b0, "pre_fwd");
    cyc();
    i_pix_valid = 1; i_pix_idx = 4'd7;
    cyc();
    i_pix_valid = 0;
    i_wr_en = 1; i_wr_bank = 2'd1; i_wr_idx = 4'd7; i_wr_color = 24'hd9d9d9;
    cyc();
    i_wr_en = 0;
    chk("fwd_c", 32'(o_pix_color), 32'hd9d9d9);
    cyc();
    lookup(7, 24'hd9d9d9, 1'b0, "post_fwd");

    // Ignored writes and illegal bank select (bank 3 does not exist)
    wr(1, 0, 24'hffffff);
    lookup(0, 24'h0, 1'b1, "wr_idx0");
    wr(3, 2, 24'habcdef);
    i_bank_sel = 2'd0;
    cyc();
    chk("sel_nofs", 32'(o_active_bank), 32'd1);
    fs(3);
    chk("sel_oob", 32'(o_active_bank), 32'd1);

    // Simultaneous write and frame_start both take effect
    i_wr_en = 1; i_wr_bank = 2'd0; i_wr_idx = 4'd4; i_wr_color = 24'h0a0b0c;
    i_frame_start = 1; i_bank_sel = 2'd0;
    cyc();
    i_wr_en = 0; i_frame_start = 0;
    chk("simul_bank", 32'(o_active_bank), 32'd0);
    lookup(4, 24'h0a0b0c, 1'b0, "simul_col");

    // Back-to-back stream of 64 pixels
    for (int i = 1; i < 16; i++)
      wr(0, i, 24'(i * 24'h010203 + 24'h100000));
    cyc();
    n_valid = 0;
    for (int i = 0; i < 64; i++) begin
      i_pix_valid = 1; i_pix_idx = IDX_W'((i * 7) % 16);
      if (i == 20) begin
        i_wr_en = 1; i_wr_bank = 2'd0; i_wr_idx = 4'd6; i_wr_color = 24'h123456;
      end
      cyc();
      i_wr_en = 0;
    end
    i_pix_valid = 0;
    cyc(); cyc(); cyc();
    chk("stream_cnt", 32'(n_valid), 32'd64);

`ifdef PALETTE_FADE_EN
    wr(0, 9, 24'hcdcdcd);
    i_fade = 8'd127;
    lookup(9, 24'h666666, 1'b0, "fade127");
    i_fade = 8'd255;
    lookup(9, 24'hcdcdcd, 1'b0, "fade255");
    i_fade = 8'd0;
    lookup(9, 24'h000000, 1'b0, "fade0");
    i_fade = 8'd255;
`endif

    // Mid-frame reset drops in-flight pixels and clears palettes/bank
    fs(1);
    i_pix_valid = 1; i_pix_idx = 4'd3;
    cyc(); cyc();
    #2 i_rst_n = 0;
    model_reset();
    #1 chk("mid_rst_valid", 32'(o_pix_valid), 32'd0);
    chk("mid_rst_bank", 32'(o_active_bank), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1;
    cyc();
    chk("post_rst_valid", 32'(o_pix_valid), 32'd0);
    i_pix_valid = 0;
    cyc(); cyc();
    lookup(5, 24'h0, 1'b0, "post_rst_mem");

    run_cmp = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
